// File: rtl/pll_dyn_ctrl_if.sv
// Update-request channel between the requesting control logic and the
// rPLL dynamic-configuration sequencer. Signal names follow the
// sequencer's point of view (i_ = into the sequencer, o_ = out of it).
interface pll_dyn_ctrl_if;
  logic       i_req;     // update request, level
  logic [3:0] i_psda;    // requested phase select
  logic [3:0] i_dutyda;  // requested duty select
  logic [3:0] i_fdly;    // requested fine delay
  logic       o_ack;     // request accepted, payload latched (1-cycle pulse)
  logic       o_done;    // update settled with lock held (1-cycle pulse)
  logic       o_busy;    // sequencer not in IDLE

  // Requester side
  modport master (
    output i_req, i_psda, i_dutyda, i_fdly,
    input  o_ack, o_done, o_busy
  );

  // Sequencer side
  modport slave (
    input  i_req, i_psda, i_dutyda, i_fdly,
    output o_ack, o_done, o_busy
  );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Sequencer for the Gowin rPLL dynamic phase/duty/fine-delay inputs and its
// RESET pin. Pulses PLL reset, waits for lock with a bounded number of
// retries, then applies requested settings and waits for them to settle
// while supervising lock. Runs in the PLL reference clock domain.
module pll_dyn_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int RST_CYCLES    = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pll_lock,
  pll_dyn_ctrl_if.slave        ctrl,
  output logic [3:0]           o_psda,
  output logic [3:0]           o_dutyda,
  output logic [3:0]           o_fdly,
  output logic                 o_pll_reset,
  output logic                 o_locked,
  output logic                 o_fault
);

  // One shared phase counter, wide enough for the longest interval.
  localparam int W_SET = $clog2(SETTLE_CYCLES + 1);
  localparam int W_LCK = $clog2(LOCK_TIMEOUT + 1);
  localparam int W_RST = $clog2(RST_CYCLES + 1);
  localparam int W_MAX = (W_SET > W_LCK) ? W_SET : W_LCK;
  localparam int CNT_W = (W_MAX > W_RST) ? W_MAX : W_RST;
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_INIT_RST,
    S_WAIT_LOCK,
    S_IDLE,
    S_SETTLE,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_retry;
  logic [RTY_W-1:0] w_retry_next;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic             w_accept;
  logic             w_settled;

  logic             r_ack;
  logic             r_done;
  logic             r_busy;
  logic             r_pll_reset;
  logic             r_locked;
  logic             r_fault;
  logic [3:0]       r_psda;
  logic [3:0]       r_dutyda;
  logic [3:0]       r_fdly;

  // Two-flop synchroniser for the asynchronous PLL LOCK pin.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its sources, regardless of block order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Next-state, retry bookkeeping and handshake events.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_accept     = 1'b0;
    w_settled    = 1'b0;
    case (r_state)
      S_INIT_RST: begin
        if (r_cnt == RST_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_next       = S_IDLE;
          w_retry_next = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_retry_next = r_retry + RTY_W'(1);
          w_next       = (w_retry_next == RTY_LIMIT) ? S_FAULT : S_INIT_RST;
        end
      end
      S_IDLE: begin
        // Lock loss wins over a simultaneous request.
        if (!r_lock_s) begin
          w_next = S_INIT_RST;
        end else if (ctrl.i_req) begin
          w_next   = S_SETTLE;
          w_accept = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!r_lock_s) begin
          w_next = S_INIT_RST;
        end else if (r_cnt == SETTLE_LAST) begin
          w_next    = S_IDLE;
          w_settled = 1'b1;
        end
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_INIT_RST;
    endcase
  end

  // State, counter and registered outputs (outputs decoded from next state).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_INIT_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b1;
      r_pll_reset <= 1'b1;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_psda      <= 4'b0000;
      r_dutyda    <= 4'b1000;
      r_fdly      <= 4'b0000;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state inside {S_INIT_RST, S_WAIT_LOCK, S_SETTLE}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_ack       <= w_accept;
      r_done      <= w_settled;
      r_busy      <= (w_next != S_IDLE);
      r_pll_reset <= (w_next == S_INIT_RST);
      r_locked    <= (w_next == S_IDLE) || (w_next == S_SETTLE);
      r_fault     <= (w_next == S_FAULT);
      if (w_accept) begin
        r_psda   <= ctrl.i_psda;
        r_dutyda <= ctrl.i_dutyda;
        r_fdly   <= ctrl.i_fdly;
      end
    end
  end

  assign ctrl.o_ack   = r_ack;
  assign ctrl.o_done  = r_done;
  assign ctrl.o_busy  = r_busy;
  assign o_psda       = r_psda;
  assign o_dutyda     = r_dutyda;
  assign o_fdly       = r_fdly;
  assign o_pll_reset  = r_pll_reset;
  assign o_locked     = r_locked;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: directed scenarios plus randomized
// lock drops, requests and resets, compared every cycle against a
// phase/remaining-time reference model.
module tb_pll_dyn_ctrl;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int RSTLEN  = 4;
  localparam int RETRIES = 2;

  localparam int PH_RESET  = 0;
  localparam int PH_LOCKWT = 1;
  localparam int PH_READY  = 2;
  localparam int PH_SETTLE = 3;
  localparam int PH_FAULT  = 4;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_pll_lock;
  logic [3:0] o_psda, o_dutyda, o_fdly;
  logic       o_pll_reset, o_locked, o_fault;

  pll_dyn_ctrl_if bus ();

  pll_dyn_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .LOCK_TIMEOUT (TIMEOUT),
    .RST_CYCLES   (RSTLEN),
    .MAX_RETRIES  (RETRIES)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_pll_lock (i_pll_lock),
    .ctrl       (bus.slave),
    .o_psda     (o_psda),
    .o_dutyda   (o_dutyda),
    .o_fdly     (o_fdly),
    .o_pll_reset(o_pll_reset),
    .o_locked   (o_locked),
    .o_fault    (o_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Reference model: current phase, cycles remaining in it, lock pipeline.
  int         m_phase, m_left, m_retries;
  logic [3:0] m_psda, m_duty, m_fdly;
  logic       m_ack, m_done;
  logic       q_lock[$];
  int         n_acks = 0, n_dones = 0, n_faults = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc_n);
    end
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    case (ph)
      PH_RESET:  m_left = RSTLEN;
      PH_LOCKWT: m_left = TIMEOUT;
      PH_SETTLE: m_left = SETTLE;
      default:   m_left = 0;
    endcase
  endtask

  // Effect of one rising edge given the inputs held across it.
  task automatic model_edge(input logic rst, input logic lock, input logic req,
                            input logic [3:0] p, input logic [3:0] d, input logic [3:0] f);
    logic ls;
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      enter(PH_RESET);
      m_retries = 0;
      m_psda = 4'd0; m_duty = 4'd8; m_fdly = 4'd0;
      q_lock = '{1'b0, 1'b0};
      return;
    end
    ls = q_lock[0];
    case (m_phase)
      PH_RESET: begin
        m_left--;
        if (m_left == 0) enter(PH_LOCKWT);
      end
      PH_LOCKWT: begin
        if (ls) begin
          m_retries = 0;
          enter(PH_READY);
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_retries++;
            enter(m_retries == RETRIES ? PH_FAULT : PH_RESET);
          end
        end
      end
      PH_READY: begin
        if (!ls) enter(PH_RESET);
        else if (req) begin
          m_ack = 1'b1;
          m_psda = p; m_duty = d; m_fdly = f;
          enter(PH_SETTLE);
        end
      end
      PH_SETTLE: begin
        if (!ls) enter(PH_RESET);
        else begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            enter(PH_READY);
          end
        end
      end
      default: ;
    endcase
    q_lock.push_back(lock);
    void'(q_lock.pop_front());
  endtask

  task automatic compare_all();
    check("ack",       {31'b0, bus.o_ack},   {31'b0, m_ack});
    check("done",      {31'b0, bus.o_done},  {31'b0, m_done});
    check("busy",      {31'b0, bus.o_busy},  {31'b0, m_phase != PH_READY});
    check("pll_reset", {31'b0, o_pll_reset}, {31'b0, m_phase == PH_RESET});
    check("locked",    {31'b0, o_locked},    {31'b0, (m_phase == PH_READY) || (m_phase == PH_SETTLE)});
    check("fault",     {31'b0, o_fault},     {31'b0, m_phase == PH_FAULT});
    check("psda",      {28'b0, o_psda},      {28'b0, m_psda});
    check("dutyda",    {28'b0, o_dutyda},    {28'b0, m_duty});
    check("fdly",      {28'b0, o_fdly},      {28'b0, m_fdly});
  endtask

  // One clock cycle: drive inputs, predict, clock, compare mid-cycle.
  task automatic cycle(input logic rst, input logic lock, input logic req,
                       input logic [3:0] p, input logic [3:0] d, input logic [3:0] f);
    i_rst = rst; i_pll_lock = lock;
    bus.i_req = req; bus.i_psda = p; bus.i_dutyda = d; bus.i_fdly = f;
    model_edge(rst, lock, req, p, d, f);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    compare_all();
    if (m_ack) n_acks++;
    if (m_done) n_dones++;
    if (m_phase == PH_FAULT) n_faults++;
  endtask

  task automatic run(input int n, input logic rst, input logic lock, input logic req);
    for (int i = 0; i < n; i++)
      cycle(rst, lock, req, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drop_left;
    i_rst = 1'b1; i_pll_lock = 1'b0;
    bus.i_req = 1'b0; bus.i_psda = '0; bus.i_dutyda = '0; bus.i_fdly = '0;
    @(negedge clk);

    // Power-up, lock rising at cycle 10, settle into IDLE.
    run(2, 1'b1, 1'b0, 1'b0);
    run(10, 1'b0, 1'b0, 1'b0);
    run(10, 1'b0, 1'b1, 1'b0);

    // Example update 5/6/3, then let it settle.
    cycle(1'b0, 1'b1, 1'b1, 4'd5, 4'd6, 4'd3);
    run(12, 1'b0, 1'b1, 1'b0);

    // Lock dropped so that lock_s is low in the third SETTLE cycle.
    cycle(1'b0, 1'b1, 1'b1, 4'd9, 4'd2, 4'd7);
    run(3, 1'b0, 1'b0, 1'b0);
    run(60, 1'b0, 1'b1, 1'b0);

    // Request arriving as lock_s falls in IDLE, held through relock.
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    run(1, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b1);
    run(20, 1'b0, 1'b1, 1'b1);
    run(15, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of SETTLE.
    cycle(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 4'd1);
    run(3, 1'b0, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1, 1'b0);
    run(30, 1'b0, 1'b1, 1'b0);

    // Lock never asserts: two retries then sticky FAULT; reset recovers.
    run(1, 1'b1, 1'b0, 1'b0);
    run(100, 1'b0, 1'b0, 1'b1);
    run(2, 1'b1, 1'b0, 1'b0);
    run(30, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional lock drops and resets.
    drop_left = 0;
    for (int i = 0; i < 2500; i++) begin
      logic lk, rs, rq;
      if (drop_left > 0) drop_left--;
      else if ($urandom_range(0, 149) == 0) drop_left = $urandom_range(1, 60);
      lk = (drop_left == 0);
      rs = ($urandom_range(0, 399) == 0);
      rq = ($urandom_range(0, 3) == 0);
      cycle(rs, lk, rq, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Scenario coverage sanity: the run must have exercised the key events.
    check("acks_seen",   {31'b0, n_acks > 10},  32'd1);
    check("dones_seen",  {31'b0, n_dones > 5},  32'd1);
    check("faults_seen", {31'b0, n_faults > 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
Sequencer for the Gowin rPLL's dynamic phase, duty and fine-delay inputs (PSDA, DUTYDA, FDLY) and its RESET pin. After reset it pulses the PLL reset, waits for qualified lock, then accepts update requests from one requester with a req/ack handshake. It waits a settle interval after each update and supervises lock, retrying PLL reset a bounded number of times before flagging a fault. It sits between the design's control logic and the PLL instance in the clock generation block, in the reference (input) clock domain.

Parameters:
SETTLE_CYCLES, 64, cycles held in SETTLE after an update before o_done (>=1)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before a retry (>=1)
RST_CYCLES, 16, length of o_pll_reset pulse in cycles (>=1)
MAX_RETRIES, 3, failed lock attempts tolerated before FAULT (>=1)

Ports:
i_clk  in  1  controller clock (PLL reference clock)
i_rst  in  1  synchronous reset, active-high
i_pll_lock  in  1  PLL LOCK, asynchronous; 2-flop synchronised internally (lock_s)
i_req  in  1  update request, level; sampled only in IDLE
i_psda  in  4  requested phase select
i_dutyda  in  4  requested duty select
i_fdly  in  4  requested fine delay
o_ack  out  1  1-cycle pulse: request accepted, payload latched
o_done  out  1  1-cycle pulse: update settled with lock held
o_busy  out  1  high in every state except IDLE
o_psda  out  4  registered PLL PSDA
o_dutyda  out  4  registered PLL DUTYDA
o_fdly  out  4  registered PLL FDLY
o_pll_reset  out  1  PLL RESET, active-high
o_locked  out  1  qualified lock: high only in IDLE/SETTLE with lock_s=1
o_fault  out  1  sticky; cleared only by i_rst

Behaviour:
- All outputs registered. Reset values (i_rst=1 on an edge):
  - state=INIT_RST; o_psda=4'b0000, o_dutyda=4'b1000, o_fdly=4'b0000.
  - o_pll_reset=1, o_busy=1; o_ack=o_done=o_locked=o_fault=0.
  - Retry count=0; synchroniser flops=0.
- States:
  - INIT_RST: o_pll_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with o_pll_reset=0.
  - WAIT_LOCK: counter runs from 0.
    - lock_s=1 -> IDLE, retry count cleared.
    - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> retry+1.
    - If the new retry count == MAX_RETRIES -> FAULT; otherwise -> INIT_RST.
  - IDLE: o_busy=0, o_locked=1.
    - lock_s=0 -> INIT_RST. This takes priority over a simultaneous i_req: no ack, payload not latched.
    - Otherwise, i_req=1 in cycle N -> in cycle N+1: o_ack=1, o_psda/o_dutyda/o_fdly = payload sampled at N, state=SETTLE.
  - SETTLE: counter runs SETTLE_CYCLES cycles (first at N+1, last at N+SETTLE_CYCLES).
    - o_done=1 at N+SETTLE_CYCLES+1, state returns to IDLE.
    - lock_s=0 in any SETTLE cycle -> INIT_RST next cycle. No o_done; new dynamic values retained.
  - FAULT: o_fault=1, o_pll_reset=0, o_busy=1, o_locked=0. Terminal until i_rst.
- i_req held high after ack: next acceptance needs IDLE again, so back-to-back accepted requests are SETTLE_CYCLES+1 cycles apart minimum. i_req is ignored outside IDLE; the payload is don't-care when not accepted.
- Lock-loss latency: i_pll_lock falling reaches lock_s after 2 edges. o_locked drops the cycle the FSM leaves IDLE/SETTLE.
- Counter widths: $clog2(max+1) of the respective parameter; no wrap; each counter cleared on state entry.
- i_rst mid-operation (any state): immediate return to reset values. A pending handshake is dropped (no o_done).

Test Plan:
Params SETTLE=8, TIMEOUT=32, RST=4, RETRIES=2.
- Power-up, lock high from cycle 10 -> o_pll_reset high cycles 1-4; IDLE with o_locked=1 ~2 cycles after lock edge; o_dutyda=8.
- In IDLE, req with psda=5, dutyda=6, fdly=3 at cycle N -> o_ack and outputs 5/6/3 at N+1, o_busy 1 through N+8, o_done at N+9.
- Lock never asserts -> two 4-cycle o_pll_reset pulses, each followed by 32 WAIT_LOCK cycles, then o_fault=1 held; i_rst clears it and resumes INIT_RST.
- Lock dropped at SETTLE cycle 3 -> no o_done, INIT_RST entered, o_pll_reset pulses 4 cycles, o_psda keeps new value, relocks to IDLE.
- i_req rises in the same cycle lock_s falls in IDLE -> no o_ack, INIT_RST; after relock, held i_req accepted.
- i_rst asserted mid-SETTLE -> next cycle all outputs at reset values, no o_done ever emitted for that request.
